hazard_ctrl: RTL

//  Pipeline scheduler for the 5-stage ARM core (F/D/E/M/W). Resolves data hazards

---
 rtl/hazard_ctrl_pkg.sv | 33 +++
 rtl/hazard_ctrl_if.sv | 54 +++++
 rtl/hazard_ctrl_fwd_sel.sv | 33 +++
 rtl/hazard_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// arm_hazard_pkg
// Shared types and constants for the 5-stage ARM core hazard controller.
//   fwd_sel_t  : E-stage operand source select (register file, W result, M result)
//   hz_state_t : scheduler states (normal run, frozen on memory wait, PC drain)
//   PC_REG     : architectural index of R15, which is never forwarded
//   regMatch   : true when a live write in a later stage targets a given source reg
// ----------------------------------------------------------------------------
package arm_hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_PC_DRAIN = 2'd2
    } hz_state_t;

    localparam logic [3:0] PC_REG = 4'd15;

    // A later stage produces a value for 'ra' when it writes and its
    // destination register equals 'ra'.
    function automatic logic regMatch(input logic we,
                                      input logic [3:0] wa,
                                      input logic [3:0] ra);
        return we && (wa == ra);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   Datapath -> controller : register addresses and write enables for D/E/M/W,
//                            load/branch/PC-write flags, memory request/ready
//   Controller -> datapath : forwarding selects and stall/flush pins
// Modports:
//   master : the pipeline datapath (drives addresses/flags, consumes controls)
//   slave  : the hazard controller
// ----------------------------------------------------------------------------
interface hazard_ctrl_if;

    logic [3:0] RA1D;
    logic [3:0] RA2D;
    logic [3:0] RA1E;
    logic [3:0] RA2E;
    logic [3:0] WA3E;
    logic [3:0] WA3M;
    logic [3:0] WA3W;
    logic       RegWriteE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemToRegE;
    logic       PCSrcD;
    logic       BranchTakenE;
    logic       MemReqM;
    logic       MemReadyM;

    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       StallM;
    logic       FlushD;
    logic       FlushE;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        output PCSrcD, BranchTakenE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemToRegE,
        input  PCSrcD, BranchTakenE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE,
        output StallF, StallD, StallE, StallM, FlushD, FlushE
    );

endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// ----------------------------------------------------------------------------
// fwd_sel
// Chooses where one E-stage source operand comes from.
//   i_RAE       : source register of the instruction in Execute
//   i_WA3M      : destination register in Memory,  i_RegWriteM its write enable
//   i_WA3W      : destination register in Writeback, i_RegWriteW its write enable
//   o_sel       : FWD_M if M produces it, else FWD_W if W does, else FWD_RF
// R15 is always read from the register file path, which carries PCPlus8.
// ----------------------------------------------------------------------------
module fwd_sel
    import arm_hazard_pkg::*;
(
    input  logic [3:0] i_RAE,
    input  logic [3:0] i_WA3M,
    input  logic       i_RegWriteM,
    input  logic [3:0] i_WA3W,
    input  logic       i_RegWriteW,
    output fwd_sel_t   o_sel
);

    // M is younger than W, so its result wins when both target the register.
    always_comb begin
        o_sel = FWD_RF;
        if (i_RAE == PC_REG) begin
            o_sel = FWD_RF;
        end else if (regMatch(i_RegWriteM, i_WA3M, i_RAE)) begin
            o_sel = FWD_M;
        end else if (regMatch(i_RegWriteW, i_WA3W, i_RAE)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
// Pipeline scheduler for the 5-stage ARM core (F/D/E/M/W): operand forwarding,
// load-use bubbles, taken-branch flushes, front-end drain behind PC writes and
// a full freeze while data memory / camera is not ready.
// Ports:
//   i_clk          : core clock, rising edge
//   i_rst          : synchronous active-high reset
//   hz (slave)     : pipeline addresses/flags in, forward selects and
//                    stall/flush pins out
//   o_MemTimeout   : sticky, memory wait lasted MEM_TIMEOUT cycles
//   o_StallCount   : saturating count of cycles with StallF high
//   o_FlushCount   : saturating count of cycles with FlushE high
// All control outputs are combinational from inputs and state.
// ----------------------------------------------------------------------------
module hazard_ctrl
    import arm_hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255,
    parameter int DRAIN_CYC   = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    hazard_ctrl_if.slave     hz,
    output logic             o_MemTimeout,
    output logic [CNT_W-1:0] o_StallCount,
    output logic [CNT_W-1:0] o_FlushCount
);

    localparam logic [1:0] S_RUN      = HZ_RUN;
    localparam logic [1:0] S_MEM_WAIT = HZ_MEM_WAIT;
    localparam logic [1:0] S_PC_DRAIN = HZ_PC_DRAIN;

    localparam int WCNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int DCNT_W = (DRAIN_CYC < 3) ? 1 : $clog2(DRAIN_CYC);
    localparam logic [WCNT_W-1:0] WCNT_LIMIT = WCNT_W'(MEM_TIMEOUT);
    // The cycle that detects the PC write is itself the first hold cycle,
    // so the counter is loaded with the number of hold cycles still to come.
    localparam logic [DCNT_W-1:0] DRAIN_LOAD = (DRAIN_CYC > 1) ? DCNT_W'(DRAIN_CYC - 1) : '0;

    logic [1:0]        r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [DCNT_W-1:0] r_dcnt;
    logic              r_memTimeout;
    logic [CNT_W-1:0]  r_stallCnt;
    logic [CNT_W-1:0]  r_flushCnt;

    logic [1:0]        w_stateNext;
    logic [WCNT_W-1:0] w_wcntNext;
    logic [DCNT_W-1:0] w_dcntNext;
    logic              w_ldUse;
    logic              w_frozen;
    logic              w_timeoutHit;
    logic              w_stallF;
    logic              w_stallD;
    logic              w_stallEM;
    logic              w_flushD;
    logic              w_flushE;
    fwd_sel_t          w_fwdA;
    fwd_sel_t          w_fwdB;

    fwd_sel u_fwdA (
        .i_RAE       (hz.RA1E),
        .i_WA3M      (hz.WA3M),
        .i_RegWriteM (hz.RegWriteM),
        .i_WA3W      (hz.WA3W),
        .i_RegWriteW (hz.RegWriteW),
        .o_sel       (w_fwdA)
    );

    fwd_sel u_fwdB (
        .i_RAE       (hz.RA2E),
        .i_WA3M      (hz.WA3M),
        .i_RegWriteM (hz.RegWriteM),
        .i_WA3W      (hz.WA3W),
        .i_RegWriteW (hz.RegWriteW),
        .o_sel       (w_fwdB)
    );

    // Hazard detection. Once frozen in MEM_WAIT only the ready line matters,
    // otherwise a new wait starts when M requests and memory is not ready.
    always_comb begin
        w_ldUse  = hz.MemToRegE && hz.RegWriteE && (hz.WA3E != PC_REG) &&
                   ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
        w_frozen = (r_state == S_MEM_WAIT) ? !hz.MemReadyM
                                           : (hz.MemReqM && !hz.MemReadyM);
    end

    // Scheduler: freeze beats everything; during a drain the front end is
    // held regardless of D; otherwise branch > load-use > PC write.
    // The cycle memory becomes ready is treated as a normal RUN cycle so a
    // branch or load-use sitting behind the freeze is still resolved.
    always_comb begin
        w_stateNext = r_state;
        w_wcntNext  = '0;
        w_dcntNext  = r_dcnt;
        w_stallF    = 1'b0;
        w_stallD    = 1'b0;
        w_stallEM   = 1'b0;
        w_flushD    = 1'b0;
        w_flushE    = 1'b0;
        if (w_frozen) begin
            w_stallF   = 1'b1;
            w_stallD   = 1'b1;
            w_stallEM  = 1'b1;
            w_wcntNext = (&r_wcnt) ? r_wcnt : r_wcnt + WCNT_W'(1);
            if (r_state != S_PC_DRAIN) begin
                w_stateNext = S_MEM_WAIT;
            end
        end else if (r_state == S_PC_DRAIN) begin
            w_stallF = 1'b1;
            w_flushD = 1'b1;
            w_flushE = hz.BranchTakenE;
            if (r_dcnt <= DCNT_W'(1)) begin
                w_stateNext = S_RUN;
                w_dcntNext  = '0;
            end else begin
                w_dcntNext = r_dcnt - DCNT_W'(1);
            end
        end else begin
            w_stateNext = S_RUN;
            if (hz.BranchTakenE) begin
                w_flushD = 1'b1;
                w_flushE = 1'b1;
            end else if (w_ldUse) begin
                w_stallF = 1'b1;
                w_stallD = 1'b1;
                w_flushE = 1'b1;
            end else if (hz.PCSrcD) begin
                w_stallF = 1'b1;
                w_flushD = 1'b1;
                if (DRAIN_CYC > 1) begin
                    w_stateNext = S_PC_DRAIN;
                    w_dcntNext  = DRAIN_LOAD;
                end
            end
        end
        w_timeoutHit = w_frozen && (w_wcntNext >= WCNT_LIMIT);
    end

    // Reset overrides the pins: nothing held, both bubble registers cleared.
    always_comb begin
        hz.ForwardAE = i_rst ? FWD_RF : w_fwdA;
        hz.ForwardBE = i_rst ? FWD_RF : w_fwdB;
        hz.StallF    = i_rst ? 1'b0 : w_stallF;
        hz.StallD    = i_rst ? 1'b0 : w_stallD;
        hz.StallE    = i_rst ? 1'b0 : w_stallEM;
        hz.StallM    = i_rst ? 1'b0 : w_stallEM;
        hz.FlushD    = i_rst ? 1'b1 : w_flushD;
        hz.FlushE    = i_rst ? 1'b1 : w_flushE;
    end

    // State, wait/drain counters, sticky timeout and saturating perf counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_RUN;
            r_wcnt       <= '0;
            r_dcnt       <= '0;
            r_memTimeout <= 1'b0;
            r_stallCnt   <= '0;
            r_flushCnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_wcnt  <= w_wcntNext;
            r_dcnt  <= w_dcntNext;
            if (w_timeoutHit) begin
                r_memTimeout <= 1'b1;
            end
            if (w_stallF && !(&r_stallCnt)) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_flushE && !(&r_flushCnt)) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
        end
    end

    assign o_MemTimeout = r_memTimeout;
    assign o_StallCount = r_stallCnt;
    assign o_FlushCount = r_flushCnt;

endmodule
